neighbourhood_scan_controller: RTL

// - Raster-scan sequencer feeding the GradientQuantization datapath. Accepts one pixel per handshake, keeps the previous

---
 rtl/neighbourhood_scan_controller_pkg.sv | 14 +
 rtl/line_buffer_ram.sv | 30 +++
 rtl/neighbourhood_scan_controller.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/neighbourhood_scan_controller_pkg.sv
// Shared constants and FSM encoding for the neighbourhood scan controller.
package neighbourhood_scan_controller_pkg;

  localparam int PKG_PIXEL_LENGTH = 8;    // sample width in bits
  localparam int PKG_MAX_WIDTH    = 512;  // line buffer depth (max pixels per row)
  localparam int PKG_DIM_LENGTH   = 16;   // width of size configuration and position counters

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } scan_state_t;

endpackage

// File: rtl/line_buffer_ram.sv
// One-row line buffer: single synchronous write port, two combinational read ports.
// Reads return the stored (previous-row) value even when the same address is written this cycle.
module line_buffer_ram #(
  parameter int pixel_length = 8,
  parameter int MAX_WIDTH    = 512,
  parameter int AW           = 9
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [pixel_length-1:0] wdata,
  input  logic [AW-1:0]           raddr0,
  output logic [pixel_length-1:0] rdata0,
  input  logic [AW-1:0]           raddr1,
  output logic [pixel_length-1:0] rdata1
);

  logic [pixel_length-1:0] mem_q [MAX_WIDTH];

  // Store the accepted sample; contents are intentionally never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata0 = mem_q[raddr0];
  assign rdata1 = mem_q[raddr1];

endmodule

// File: rtl/neighbourhood_scan_controller.sv
// Raster-scan sequencer: accepts one pixel per handshake and presents the current
// sample x with its causal neighbours a (W), b (N), c (NW), d (NE), applying the
// image-edge substitutions used by the gradient quantizer.
module neighbourhood_scan_controller
  import neighbourhood_scan_controller_pkg::*;
#(
  parameter int pixel_length = PKG_PIXEL_LENGTH,
  parameter int MAX_WIDTH    = PKG_MAX_WIDTH,
  parameter int dim_length   = PKG_DIM_LENGTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [dim_length-1:0]   frame_width,
  input  logic [dim_length-1:0]   frame_height,
  input  logic [pixel_length-1:0] pix_in,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  output logic [pixel_length-1:0] x,
  output logic [pixel_length-1:0] a,
  output logic [pixel_length-1:0] b,
  output logic [pixel_length-1:0] c,
  output logic [pixel_length-1:0] d,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [dim_length-1:0]   col,
  output logic [dim_length-1:0]   row,
  output logic                    frame_done,
  output logic                    busy
);

  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  scan_state_t state_q, state_d;

  // Frame geometry latched at start, and the position of the next pixel to accept.
  logic [dim_length-1:0]   width_q, height_q;
  logic [dim_length-1:0]   ccol_q, crow_q;
  logic                    first_row_q;
  logic [pixel_length-1:0] rc_next_q;

  // Registered output stage.
  logic [pixel_length-1:0] x_q, a_q, b_q, c_q, d_q;
  logic [dim_length-1:0]   col_q, row_q;
  logic                    out_valid_q, frame_done_q;

  // Neighbours computed for the pixel being accepted this cycle.
  logic [pixel_length-1:0] a_d, b_d, c_d, d_d;
  logic                    frame_done_d;

  logic                    accept, consume;
  logic                    col0, last_col, last_row;
  logic [AW-1:0]           addr0, addr1;
  logic [pixel_length-1:0] rd0, rd1;

  assign busy      = (state_q != IDLE);
  assign pix_ready = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept    = pix_valid && pix_ready;
  assign consume   = out_valid_q && out_ready;

  assign col0     = (ccol_q == '0);
  assign last_col = (ccol_q == width_q - dim_length'(1));
  assign last_row = (crow_q == height_q - dim_length'(1));

  // North-east read only steps past col when col is not the last column, so it never leaves the row.
  assign addr0 = ccol_q[AW-1:0];
  assign addr1 = last_col ? addr0 : addr0 + AW'(1);

  line_buffer_ram #(
    .pixel_length (pixel_length),
    .MAX_WIDTH    (MAX_WIDTH),
    .AW           (AW)
  ) u_line_buffer (
    .clk    (clk),
    .we     (accept),
    .waddr  (addr0),
    .wdata  (pix_in),
    .raddr0 (addr0),
    .rdata0 (rd0),
    .raddr1 (addr1),
    .rdata1 (rd1)
  );

  // Edge substitution: first row sees zeros above; column 0 borrows b for a and the
  // saved row-start Ra for c; the last column replicates b into d.
  always_comb begin
    b_d = first_row_q ? '0 : rd0;
    d_d = first_row_q ? '0 : (last_col ? b_d : rd1);
    a_d = col0 ? b_d : x_q;
    c_d = col0 ? rc_next_q : b_q;
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DRAIN after the last pixel, DRAIN -> IDLE once it is consumed.
  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept && last_col && last_row) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (consume) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and frame-done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Geometry latch, raster position counters, first-row flag and row-start Ra.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      width_q     <= '0;
      height_q    <= '0;
      ccol_q      <= '0;
      crow_q      <= '0;
      first_row_q <= 1'b1;
      rc_next_q   <= '0;
    end else if ((state_q == IDLE) && start) begin
      width_q     <= frame_width;
      height_q    <= frame_height;
      ccol_q      <= '0;
      crow_q      <= '0;
      first_row_q <= 1'b1;
      rc_next_q   <= '0;
    end else if (accept) begin
      if (col0) begin
        rc_next_q <= a_d;
      end
      if (last_col) begin
        ccol_q      <= '0;
        crow_q      <= crow_q + dim_length'(1);
        first_row_q <= 1'b0;
      end else begin
        ccol_q <= ccol_q + dim_length'(1);
      end
    end
  end

  // Output register: load on accept, hold while stalled, drop valid once consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      x_q         <= pix_in;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      d_q         <= d_d;
      col_q       <= ccol_q;
      row_q       <= crow_q;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign x          = x_q;
  assign a          = a_q;
  assign b          = b_q;
  assign c          = c_q;
  assign d          = d_q;
  assign col        = col_q;
  assign row        = row_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;

endmodule
